// File: rtl/riscv_data_mem_responder.sv
// ============================================================================
// Module  : riscv_data_mem_responder
// Purpose : Data-port memory responder for riscv_core: byte/half/word loads and
//           stores on a word-organised RAM after WAIT_STATES wait cycles.
//           Optional macro DMEM_BOUNDS_CHECK_EN rejects out-of-range indices.
// Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_data_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_address,
    input  logic [31:0] data_out,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [1:0]  data_size,
    input  logic        data_unsigned,
    output logic [31:0] data_in,
    output logic        data_ready,
    output logic        data_error,
    output logic        busy
);

    localparam int         IDX_W       = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] c_SZ_BYTE   = 2'b00;
    localparam logic [1:0] c_SZ_HALF   = 2'b01;
    localparam logic [1:0] c_SZ_WORD   = 2'b10;
    localparam logic [1:0] c_SZ_ILL    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_cnt;
    logic               r_busy;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_lane;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [31:0]        r_wdata;
    logic               r_write;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH];

    logic [31:0]        w_offset;
    logic               w_oob;
    logic               w_misalign;
    logic               w_reject;
    logic               w_accept;
    logic               w_we;
    logic [3:0]         w_be;
    logic [31:0]        w_wrep;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load;

    assign w_offset = data_address - BASE_ADDR;

`ifdef DMEM_BOUNDS_CHECK_EN
    // Any set bit above the index field means word index >= DEPTH (incl. wrap below base).
    assign w_oob = |w_offset[31:IDX_W+2];
`else
    assign w_oob = 1'b0;
`endif

    assign w_misalign = ((data_size == c_SZ_HALF) && data_address[0]) ||
                        ((data_size == c_SZ_WORD) && (data_address[1:0] != 2'b00));
    assign w_reject   = (data_size == c_SZ_ILL) || w_misalign ||
                        (data_read && data_write) || w_oob;

    // busy stays high through the data_ready cycle, so a request still held
    // by the core in that cycle is not sampled a second time.
    assign w_accept = (r_state == S_IDLE) && !r_busy && (data_read || data_write);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= 4'd0;
            r_busy     <= 1'b0;
            r_idx      <= '0;
            r_lane     <= 2'b00;
            r_size     <= 2'b00;
            r_uns      <= 1'b0;
            r_wdata    <= 32'd0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            data_in    <= 32'd0;
            data_ready <= 1'b0;
            data_error <= 1'b0;
        end else begin
            data_ready <= 1'b0;
            data_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (data_ready) begin
                        r_busy <= 1'b0;
                    end else if (w_accept) begin
                        r_busy  <= 1'b1;
                        r_cnt   <= c_WAIT_LOAD;
                        r_idx   <= w_offset[IDX_W+1:2];
                        r_lane  <= data_address[1:0];
                        r_size  <= data_size;
                        r_uns   <= data_unsigned;
                        r_wdata <= data_out;
                        r_write <= data_write;
                        r_err   <= w_reject;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    data_ready <= 1'b1;
                    data_error <= r_err;
                    if (r_err)         data_in <= 32'd0;
                    else if (!r_write) data_in <= w_load;
                end
                default: ;
            endcase
        end
    end

    assign busy = r_busy;

    // Load path
    assign w_word = r_mem[r_idx];

    always_comb begin
        w_byte = w_word[7:0];
        case (r_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load = w_word;
        case (r_size)
            c_SZ_BYTE: w_load = r_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: w_load = r_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
            default:   w_load = w_word;
        endcase
    end

    // Store path: commits on the same edge that raises data_ready
    assign w_we = (r_state == S_RESP) && r_write && !r_err;

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = r_wdata;
        case (r_size)
            c_SZ_BYTE: begin
                w_be   = 4'b0001 << r_lane;
                w_wrep = {4{r_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_be   = r_lane[1] ? 4'b1100 : 4'b0011;
                w_wrep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be   = 4'b1111;
                w_wrep = r_wdata;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[r_idx][8*i +: 8] <= w_wrep[8*i +: 8];
            end
        end
    end

endmodule

`default_nettype wire
